pipe_skid_latch: RTL

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer: one output entry plus one skid entry. Payload is split into a data field and a control field. It adds synchronous flush, per-bit control clear on a memory hit while stalled, and zero-filled bubbles. It sits between any two CPU pipeline stages, e.g. EX/MEM and MEM/WB, and replaces the fixed-field latch with stall/flush. Because `in_ready` is registered, there is no combinational path from `out_ready` to `in_ready`.

---
 rtl/pipe_skid_latch.sv | 99 +++++++++
 1 files changed

// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: valid/ready pipeline stage with one skid entry, flush, hit-driven ctrl clear and zeroed bubbles.
module pipe_skid_latch #(
    parameter int DATA_W = 128,
    parameter int CTRL_W = 16,
    parameter logic [CTRL_W-1:0] HIT_CLR_MASK = '0
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              flush,
    input  logic              hit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);
    // state encoding doubles as the occupancy count
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t              r_state, w_state_nxt;
    logic                r_in_ready, r_out_valid;
    logic [DATA_W-1:0]   r_out_data, r_skid_data, w_out_data_nxt, w_skid_data_nxt;
    logic [CTRL_W-1:0]   r_out_ctrl, r_skid_ctrl, w_out_ctrl_nxt, w_skid_ctrl_nxt;
    logic                w_in_fire, w_out_fire;
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_ctrl   = r_out_ctrl;
    assign occupancy  = r_state;
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ctrl  <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_state_nxt != FULL;
            r_out_valid <= w_state_nxt != EMPTY;
            r_out_data  <= w_out_data_nxt;
            r_out_ctrl  <= w_out_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
        end
    end
    always_comb begin
        w_state_nxt     = r_state;
        w_out_data_nxt  = r_out_data;
        w_out_ctrl_nxt  = r_out_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        if (flush) begin
            w_state_nxt     = EMPTY;
            w_out_data_nxt  = '0;
            w_out_ctrl_nxt  = '0;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            case (r_state)
                EMPTY: if (w_in_fire) begin
                    w_state_nxt    = ONE;
                    w_out_data_nxt = in_data;
                    w_out_ctrl_nxt = in_ctrl;
                end
                ONE: if (w_in_fire && w_out_fire) begin
                    w_out_data_nxt = in_data;
                    w_out_ctrl_nxt = in_ctrl;
                end else if (w_in_fire) begin
                    w_state_nxt     = FULL;
                    w_skid_data_nxt = in_data;
                    w_skid_ctrl_nxt = in_ctrl;
                end else if (w_out_fire) begin
                    w_state_nxt    = EMPTY;
                    w_out_data_nxt = '0;
                    w_out_ctrl_nxt = '0;
                end
                FULL: if (w_out_fire) begin
                    w_state_nxt     = ONE;
                    w_out_data_nxt  = r_skid_data;
                    w_out_ctrl_nxt  = r_skid_ctrl;
                    w_skid_data_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                end
                default: w_state_nxt = EMPTY;
            endcase
            // a stalled, already-serviced request must not be re-issued downstream
            if (r_out_valid && !out_ready && hit)
                w_out_ctrl_nxt = r_out_ctrl & ~HIT_CLR_MASK;
        end
    end
endmodule
